// File: rtl/gemac_pause_ctrl_pkg.sv
// Shared constants and helpers for the simple_gemac pause-frame scheduler.
package gemac_pause_ctrl_pkg;

  localparam logic        ST_IDLE     = 1'b0;
  localparam logic        ST_PAUSED   = 1'b1;
  localparam logic [15:0] PAUSE_XON   = 16'h0000;
  localparam int          HOLDOFF_DEF = 128;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gemac_dncnt.sv
// Loadable down-counter that stops at zero; used for both holdoff and refresh timing.
module gemac_dncnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load, load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gemac_pause_ctrl.sv
// Pause-frame scheduler: XOFF above the high watermark, periodic XOFF refresh while
// paused, XON below the low watermark, with a holdoff gate between request pulses.
module gemac_pause_ctrl
  import gemac_pause_ctrl_pkg::*;
#(
  parameter int LEVEL_W = 16,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic [LEVEL_W-1:0] thresh_hi,
  input  logic [LEVEL_W-1:0] thresh_lo,
  input  logic [15:0]        pause_quanta,
  input  logic [15:0]        refresh_cycles,
  output logic               pause_req,
  output logic [15:0]        pause_time,
  output logic               paused,
  output logic [15:0]        pause_count
);

  localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF - 1);

  logic        state_q,       state_d;
  logic        pause_req_q,   pause_req_d;
  logic [15:0] pause_time_q,  pause_time_d;
  logic [15:0] pause_count_q, pause_count_d;

  logic [15:0] holdoff_cnt_s;
  logic        holdoff_zero_s;
  logic [15:0] refresh_cnt_s;
  logic        refresh_zero_s;
  logic        refresh_load_s;
  logic        refresh_dec_s;
  logic        gate_open_s;
  logic        xoff_cond_s;
  logic        xon_cond_s;

  gemac_dncnt #(.W(16)) u_holdoff (
    .clk      (clk),
    .rst      (reset),
    .clr      (clear),
    .load     (pause_req_d),
    .load_val (HOLDOFF_LOAD),
    .dec      (1'b1),
    .cnt      (holdoff_cnt_s),
    .zero     (holdoff_zero_s)
  );

  gemac_dncnt #(.W(16)) u_refresh (
    .clk      (clk),
    .rst      (reset),
    .clr      (clear),
    .load     (refresh_load_s),
    .load_val (refresh_cycles),
    .dec      (refresh_dec_s),
    .cnt      (refresh_cnt_s),
    .zero     (refresh_zero_s)
  );

  // The previous-pulse term keeps pulses apart even if HOLDOFF is built as 1.
  assign gate_open_s = holdoff_zero_s & ~pause_req_q;
  assign xoff_cond_s = enable & (pause_quanta != PAUSE_XON) & (fifo_level >= thresh_hi);
  assign xon_cond_s  = ~enable | (pause_quanta == PAUSE_XON) | (fifo_level <= thresh_lo);

  // FSM and pulse scheduling.
  always_comb begin
    state_d        = state_q;
    pause_req_d    = 1'b0;
    pause_time_d   = pause_time_q;
    refresh_load_s = 1'b0;
    refresh_dec_s  = 1'b0;
    if (clear) begin
      state_d      = ST_IDLE;
      pause_time_d = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xoff_cond_s && gate_open_s) begin
            pause_req_d    = 1'b1;
            pause_time_d   = pause_quanta;
            refresh_load_s = 1'b1;
            state_d        = ST_PAUSED;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PAUSED: begin
          // XON outranks a refresh that falls due in the same cycle.
          if (xon_cond_s) begin
            if (gate_open_s) begin
              pause_req_d  = 1'b1;
              pause_time_d = PAUSE_XON;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_PAUSED;
            end
          end else if ((refresh_cycles != 16'h0000) && refresh_zero_s && gate_open_s) begin
            pause_req_d    = 1'b1;
            pause_time_d   = pause_quanta;
            refresh_load_s = 1'b1;
          end else begin
            refresh_dec_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pulse counter saturates at all-ones.
  always_comb begin
    pause_count_d = pause_count_q;
    if (clear) begin
      pause_count_d = 16'h0000;
    end else if (pause_req_d) begin
      pause_count_d = sat_inc16(pause_count_q);
    end else begin
      pause_count_d = pause_count_q;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pause_req_q   <= 1'b0;
      pause_time_q  <= 16'h0000;
      pause_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pause_req_q   <= pause_req_d;
      pause_time_q  <= pause_time_d;
      pause_count_q <= pause_count_d;
    end
  end

  assign pause_req   = pause_req_q;
  assign pause_time  = pause_time_q;
  assign paused      = (state_q == ST_PAUSED);
  assign pause_count = pause_count_q;

endmodule

// File: tb/tb_gemac_pause_ctrl.sv
// Scoreboard bench for gemac_pause_ctrl: scenarios push expected pulses, a monitor checks them.
module tb_gemac_pause_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        enable;
  logic [15:0] fifo_level;
  logic [15:0] thresh_hi;
  logic [15:0] thresh_lo;
  logic [15:0] pause_quanta;
  logic [15:0] refresh_cycles;
  logic        pause_req;
  logic [15:0] pause_time;
  logic        paused;
  logic [15:0] pause_count;

  typedef struct {
    int          cyc;
    logic [15:0] tm;
    logic        pd;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  gemac_pause_ctrl #(.LEVEL_W(16), .HOLDOFF(128)) dut (
    .clk            (clk),
    .reset          (rst),
    .clear          (clear),
    .enable         (enable),
    .fifo_level     (fifo_level),
    .thresh_hi      (thresh_hi),
    .thresh_lo      (thresh_lo),
    .pause_quanta   (pause_quanta),
    .refresh_cycles (refresh_cycles),
    .pause_req      (pause_req),
    .pause_time     (pause_time),
    .paused         (paused),
    .pause_count    (pause_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && pause_req) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: cyc=%0d pause_time=%h, required no pulse", cyc, pause_time);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || pause_time !== e.tm || paused !== e.pd) begin
            n_err++;
            $display("FAIL pulse: got cyc=%0d time=%h paused=%b, required cyc=%0d time=%h paused=%b",
                     cyc, pause_time, paused, e.cyc, e.tm, e.pd);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic [15:0] tm, input logic pd);
    exp_t e;
    e.cyc = c;
    e.tm  = tm;
    e.pd  = pd;
    exp_q.push_back(e);
  endtask

  task automatic quiesce();
    enable     = 1'b0;
    fifo_level = 16'd0;
    clear      = 1'b1;
    tick(1);
    clear      = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; enable = 1'b0; fifo_level = 16'd0;
    thresh_hi = 16'd12; thresh_lo = 16'd4; pause_quanta = 16'd7; refresh_cycles = 16'd0;
    tick(3);
    n_cmp++;
    if ({pause_req, paused, pause_time, pause_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_state: got req=%b paused=%b time=%h count=%h, required all 0",
               pause_req, paused, pause_time, pause_count);
    end
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if ({pause_req, paused, pause_count} !== 18'd0) begin
      n_err++;
      $display("FAIL post_reset_idle: got req=%b paused=%b count=%h, required all 0", pause_req, paused, pause_count);
    end
  endtask

  task automatic test_basic();
    quiesce();
    refresh_cycles = 16'd0;
    enable = 1'b1;
    fifo_level = 16'd12;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(200);
    fifo_level = 16'd4;
    push_exp(cyc + 1, 16'd0, 1'b0);
    tick(5);
    n_cmp++;
    if (paused !== 1'b0 || pause_count !== 16'd2 || pause_time !== 16'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_end: got paused=%b count=%0d time=%h pending=%0d, required 0/2/0000/0",
               paused, pause_count, pause_time, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_refresh();
    int c;
    quiesce();
    refresh_cycles = 16'd300;
    enable = 1'b1;
    fifo_level = 16'd15;
    c = cyc;
    for (int k = 0; k < 4; k++) push_exp(c + 1 + 301 * k, 16'd7, 1'b1);
    tick(1000);
    n_cmp++;
    if (paused !== 1'b1 || pause_count !== 16'd4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL refresh_end: got paused=%b count=%0d pending=%0d, required 1/4/0",
               paused, pause_count, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_holdoff();
    quiesce();
    refresh_cycles = 16'd0;
    enable = 1'b1;
    fifo_level = 16'd12;
    push_exp(cyc + 1, 16'd7, 1'b1);
    push_exp(cyc + 1 + 128, 16'd0, 1'b0);
    tick(10);
    fifo_level = 16'd4;
    tick(140);
    n_cmp++;
    if (paused !== 1'b0 || pause_count !== 16'd2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL holdoff_xon: got paused=%b count=%0d pending=%0d, required 0/2/0",
               paused, pause_count, exp_q.size());
      exp_q.delete();
    end
    quiesce();
    enable = 1'b1;
    fifo_level = 16'd12;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(10);
    fifo_level = 16'd4;
    tick(50);
    fifo_level = 16'd12;
    tick(200);
    n_cmp++;
    if (paused !== 1'b1 || pause_count !== 16'd1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL holdoff_cancel: got paused=%b count=%0d pending=%0d, required 1/1/0",
               paused, pause_count, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    quiesce();
    refresh_cycles = 16'd300;
    enable = 1'b1;
    fifo_level = 16'd15;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(301);
    fifo_level = 16'd4;
    push_exp(cyc + 1, 16'd0, 1'b0);
    tick(10);
    n_cmp++;
    if (paused !== 1'b0 || pause_count !== 16'd2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL simultaneous: got paused=%b count=%0d pending=%0d, required 0/2/0",
               paused, pause_count, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_disable_clear();
    quiesce();
    refresh_cycles = 16'd0;
    enable = 1'b1;
    fifo_level = 16'd15;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(200);
    enable = 1'b0;
    push_exp(cyc + 1, 16'd0, 1'b0);
    tick(5);
    n_cmp++;
    if (paused !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL disable_xon: got paused=%b pending=%0d, required 0/0", paused, exp_q.size());
      exp_q.delete();
    end
    quiesce();
    enable = 1'b1;
    push_exp(cyc + 1, 16'd7, 1'b1);
    fifo_level = 16'd15;
    tick(200);
    clear = 1'b1;
    enable = 1'b0;
    tick(1);
    clear = 1'b0;
    n_cmp++;
    if ({pause_req, paused, pause_time, pause_count} !== 34'd0) begin
      n_err++;
      $display("FAIL clear_paused: got req=%b paused=%b time=%h count=%h, required all 0",
               pause_req, paused, pause_time, pause_count);
    end
    tick(5);
    enable = 1'b1;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pause_req, paused, pause_time, pause_count} !== 34'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b paused=%b time=%h count=%h pending=%0d, required all 0",
               pause_req, paused, pause_time, pause_count, exp_q.size());
      exp_q.delete();
    end
    enable = 1'b0;
    fifo_level = 16'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_config_edges();
    quiesce();
    refresh_cycles = 16'd0;
    pause_quanta = 16'd0;
    enable = 1'b1;
    fifo_level = 16'd20;
    tick(200);
    n_cmp++;
    if (paused !== 1'b0 || pause_count !== 16'd0) begin
      n_err++;
      $display("FAIL zero_quanta: got paused=%b count=%0d, required 0/0", paused, pause_count);
    end
    force dut.pause_count_q = 16'hFFFE;
    tick(1);
    release dut.pause_count_q;
    pause_quanta = 16'd7;
    push_exp(cyc + 1, 16'd7, 1'b1);
    tick(1);
    fifo_level = 16'd4;
    push_exp(cyc + 128, 16'd0, 1'b0);
    tick(128);
    fifo_level = 16'd20;
    push_exp(cyc + 128, 16'd7, 1'b1);
    tick(140);
    n_cmp++;
    if (pause_count !== 16'hFFFF || paused !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL count_saturate: got count=%h paused=%b pending=%0d, required FFFF/1/0",
               pause_count, paused, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_refresh();
    test_holdoff();
    test_simultaneous();
    test_disable_clear();
    test_config_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
